// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: per-channel duty scheduler in front of pwm generators.
// Define PWM_SEQ_RAMP_EN for 1%-per-step slewing; otherwise duty jumps.
module pwm_duty_sequencer #(
  parameter int NUM_CH   = 2,
  parameter int STEP_DIV = 1000,
  parameter int MAX_DUTY = 100,
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                one_MHz_enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CW-1:0]       cmd_ch,
  input  logic [6:0]          cmd_duty,
  input  logic                estop,
  output logic [7*NUM_CH-1:0] duty_flat,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done,
  output logic                stopped
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    ESTOP
  } state_t;

  localparam logic [6:0] MAXD = 7'(MAX_DUTY);

  state_t                  state;
  logic [NUM_CH-1:0][6:0]  duty;
  logic [NUM_CH-1:0][6:0]  target;
  logic [NUM_CH-1:0]       sel;
  logic [6:0]              clamped;
  logic                    acc;

  assign cmd_ready = (state != ESTOP) && !estop;
  assign acc       = cmd_valid && cmd_ready;
  assign clamped   = (cmd_duty > MAXD) ? MAXD : cmd_duty;
  assign duty_flat = duty;

  // out-of-range channel indices match no sel bit and are dropped
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel[k] = acc && (cmd_ch == CW'(k));
    end
  end

`ifdef PWM_SEQ_RAMP_EN
  logic [15:0]            presc;
  logic [15:0]            presc_n;
  logic                   step;
  logic [NUM_CH-1:0][6:0] duty_n;
  logic [NUM_CH-1:0][6:0] tgt_n;

  // step moves toward the old target; a same-cycle command lands after
  always_comb begin
    step    = 1'b0;
    presc_n = presc;
    if (one_MHz_enable) begin
      if (presc == 16'(STEP_DIV - 1)) begin
        presc_n = '0;
        step    = 1'b1;
      end else begin
        presc_n = presc + 16'd1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_n[k]  = sel[k] ? clamped : target[k];
      duty_n[k] = duty[k];
      if (step) begin
        if (duty[k] < target[k]) begin
          duty_n[k] = duty[k] + 7'd1;
        end else if (duty[k] > target[k]) begin
          duty_n[k] = duty[k] - 7'd1;
        end
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = one_MHz_enable ^ (^target) ^ (STEP_DIV != 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      stopped <= 1'b0;
      busy    <= '0;
      done    <= '0;
      duty    <= '0;
      target  <= '0;
`ifdef PWM_SEQ_RAMP_EN
      presc   <= '0;
`endif
    end else if (estop) begin
      state   <= ESTOP;
      stopped <= 1'b1;
      busy    <= '0;
      done    <= '0;
      duty    <= '0;
      target  <= '0;
`ifdef PWM_SEQ_RAMP_EN
      presc   <= '0;
`endif
    end else begin
      stopped <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      presc  <= presc_n;
      duty   <= duty_n;
      target <= tgt_n;
      for (int k = 0; k < NUM_CH; k++) begin
        busy[k] <= duty_n[k] != tgt_n[k];
        done[k] <= step && (duty[k] != target[k])
                   && (duty_n[k] == target[k]);
      end
      unique case (state)
        IDLE:    if (|busy) state <= RAMP;
        RAMP:    if (!(|busy)) state <= IDLE;
        ESTOP:   state <= IDLE;
        default: state <= IDLE;
      endcase
`else
      state <= IDLE;
      done  <= sel;
      for (int k = 0; k < NUM_CH; k++) begin
        if (sel[k]) begin
          duty[k]   <= clamped;
          target[k] <= clamped;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed checks for pwm_duty_sequencer.
// STEP_DIV=4 with one_MHz_enable every 2 clocks gives 8 clocks per step.
module tb_pwm_duty_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_ch = 1'b0;
  logic [6:0]  cmd_duty = '0;
  logic        estop = 1'b0;
  logic [13:0] duty_flat;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic        stopped;

  int          checks = 0;
  int          errors = 0;
  int          done0_cnt = 0;
  logic [6:0]  max_d1 = '0;
  bit          en_run = 1'b0;
  logic [6:0]  d;
  int          n;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .NUM_CH(2),
    .STEP_DIV(4),
    .MAX_DUTY(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .one_MHz_enable(en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch),
    .cmd_duty(cmd_duty),
    .estop(estop),
    .duty_flat(duty_flat),
    .busy(busy),
    .done(done),
    .stopped(stopped)
  );

  function automatic logic [6:0] dch(input int ch);
    return (ch == 0) ? duty_flat[6:0] : duty_flat[13:7];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    en = en_run ? ~en : 1'b0;
    if (done[0]) done0_cnt++;
    if (duty_flat[13:7] > max_d1) max_d1 = duty_flat[13:7];
  endtask

  task automatic cmd(input logic ch, input logic [6:0] dv);
    cmd_ch    = ch;
    cmd_duty  = dv;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_change(input int ch, input int bound,
                             output logic [6:0] v, output int cyc);
    logic [6:0] start;
    start = dch(ch);
    cyc = 0;
    while (cyc < bound && dch(ch) == start) begin
      tick();
      cyc++;
    end
    v = dch(ch);
  endtask

  task automatic wait_val(input int ch, input logic [6:0] val,
                          input int bound);
    int c;
    c = 0;
    while (c < bound && dch(ch) != val) begin
      tick();
      c++;
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_duty", duty_flat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stopped", stopped, 0);
    chk("rst_ready", cmd_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    en_run = 1'b1;
    tick();

`ifdef PWM_SEQ_RAMP_EN
    cmd(1'b0, 7'd5);
    chk("acc_busy", busy, 2'b01);
    chk("acc_duty0", dch(0), 0);
    for (int v = 1; v <= 5; v++) begin
      wait_change(0, 20, d, n);
      chk("ramp0_val", d, v);
      if (v > 1) chk("ramp0_period", n, 8);
      chk("ramp0_busy", busy[0], v < 5);
      chk("ramp0_done", done[0], v == 5);
    end
    tick();
    chk("ramp0_done_end", done, 0);

    max_d1 = '0;
    cmd(1'b1, 7'd120);
    wait_val(1, 7'd100, 900);
    chk("clamp_reach", dch(1), 100);
    repeat (30) tick();
    chk("clamp_hold", dch(1), 100);
    chk("clamp_max", max_d1, 100);
    chk("clamp_busy", busy, 0);

    cmd(1'b0, 7'd0);
    wait_val(0, 7'd0, 60);
    cmd(1'b0, 7'd10);
    wait_val(0, 7'd3, 60);
    chk("retgt_at3", dch(0), 3);
    cmd(1'b0, 7'd1);
    done0_cnt = 0;
    wait_change(0, 20, d, n);
    chk("retgt_2", d, 2);
    wait_change(0, 20, d, n);
    chk("retgt_1", d, 1);
    repeat (20) tick();
    chk("retgt_done_cnt", done0_cnt, 1);
    chk("retgt_hold", dch(0), 1);

    cmd(1'b0, 7'd40);
    cmd(1'b1, 7'd60);
    repeat (40) tick();
    chk("pre_estop_busy", busy, 2'b11);
    estop = 1'b1;
    #1;
    chk("estop_ready", cmd_ready, 0);
    tick();
    chk("estop_duty", duty_flat, 0);
    chk("estop_stopped", stopped, 1);
    chk("estop_busy", busy, 0);
    chk("estop_done", done, 0);
    estop = 1'b0;
    #1;
    chk("estop_rel_ready", cmd_ready, 0);
    tick();
    chk("idle_stopped", stopped, 0);
    chk("idle_ready", cmd_ready, 1);
    repeat (30) tick();
    chk("idle_duty", duty_flat, 0);
    chk("idle_busy", busy, 0);

    cmd(1'b0, 7'd20);
    repeat (30) tick();
    chk("pre_rst_nonzero", dch(0) != 0, 1);
    #3 reset = 1'b0;
    #1;
    chk("arst_duty", duty_flat, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_stopped", stopped, 0);
    tick();
    reset = 1'b1;
    cmd(1'b0, 7'd2);
    wait_change(0, 20, d, n);
    chk("post_rst_1", d, 1);
    wait_change(0, 20, d, n);
    chk("post_rst_2", d, 2);
`else
    chk("acc_ready", cmd_ready, 1);
    cmd(1'b0, 7'd77);
    chk("direct_duty0", dch(0), 77);
    chk("direct_done0", done, 2'b01);
    chk("direct_busy", busy, 0);
    tick();
    chk("direct_done_end", done, 0);
    chk("direct_hold0", dch(0), 77);
    cmd(1'b1, 7'd120);
    chk("direct_clamp", dch(1), 100);
    chk("direct_done1", done, 2'b10);
    cmd(1'b1, 7'd30);
    chk("direct_both", duty_flat, {7'd30, 7'd77});

    estop = 1'b1;
    cmd_ch = 1'b0;
    cmd_duty = 7'd50;
    cmd_valid = 1'b1;
    #1;
    chk("estop_ready", cmd_ready, 0);
    tick();
    chk("estop_duty", duty_flat, 0);
    chk("estop_stopped", stopped, 1);
    chk("estop_done", done, 0);
    estop = 1'b0;
    #1;
    chk("estop_rel_ready", cmd_ready, 0);
    tick();
    chk("idle_stopped", stopped, 0);
    chk("idle_duty", duty_flat, 0);
    chk("idle_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("post_estop_cmd", dch(0), 50);
    chk("post_estop_done", done, 2'b01);

    #3 reset = 1'b0;
    #1;
    chk("arst_duty", duty_flat, 0);
    chk("arst_done", done, 0);
    chk("arst_stopped", stopped, 0);
    tick();
    reset = 1'b1;
    cmd(1'b1, 7'd9);
    chk("post_rst_cmd", duty_flat, {7'd9, 7'd0});
    chk("post_rst_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
